ddr_line_server: RTL

Memory-side responder for the cache's 128-bit line interface (cache2DDR_* requests / DDR2cache_* completions). Accepts one line read or line write at a time and translates it into a MIG-style native app command/data handshake toward the DDR controller. Returns completion pulses and read data to the cache.

---
 rtl/ddr_line_server.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ddr_line_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_line_server: single-outstanding 128-bit cache line server that        |
// | bridges cache2DDR_* requests onto a MIG-style native app interface.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ddr_line_server #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int APP_ADDR_W  = 27
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [26:0]           cache2DDR_rd_addr,
    input  logic                  cache2DDR_rd_en,
    output logic                  DDR2cache_rd_fin,
    output logic [127:0]          DDR2cache_rd_data,
    input  logic [26:0]           cache2DDR_wr_addr,
    input  logic [127:0]          cache2DDR_wr_data,
    input  logic                  cache2DDR_wr_en,
    output logic                  DDR2cache_wr_fin,
    input  logic                  init_calib_complete,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [127:0]          app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [127:0]          app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        RD_FIN  = 3'd3,
        WR_XFER = 3'd4,
        WR_FIN  = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t        state_q, state_d;
    logic          rd_armed_q, rd_armed_d;
    logic          wr_armed_q, wr_armed_d;
    logic          rd_pend_q, rd_pend_d;
    logic [22:0]   rd_line_q, rd_line_d;
    logic [22:0]   wr_line_q, wr_line_d;
    logic [127:0]  wr_data_q, wr_data_d;
    logic [127:0]  rd_data_q, rd_data_d;
    logic          cmd_done_q, cmd_done_d;
    logic          data_done_q, data_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          rd_req, wr_req;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{cache2DDR_rd_addr[3:0], cache2DDR_wr_addr[3:0]};

    assign rd_req = cache2DDR_rd_en && rd_armed_q;
    assign wr_req = cache2DDR_wr_en && wr_armed_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rd_armed_q  <= 1'b1;
            wr_armed_q  <= 1'b1;
            rd_pend_q   <= 1'b0;
            rd_line_q   <= '0;
            wr_line_q   <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_armed_q  <= rd_armed_d;
            wr_armed_q  <= wr_armed_d;
            rd_pend_q   <= rd_pend_d;
            rd_line_q   <= rd_line_d;
            wr_line_q   <= wr_line_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_armed_d  = cache2DDR_rd_en ? rd_armed_q : 1'b1;
        wr_armed_d  = cache2DDR_wr_en ? wr_armed_q : 1'b1;
        rd_pend_d   = rd_pend_q;
        rd_line_d   = rd_line_q;
        wr_line_d   = wr_line_q;
        wr_data_d   = wr_data_q;
        rd_data_d   = rd_data_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        app_en           = 1'b0;
        app_cmd          = 3'b000;
        app_addr         = '0;
        app_wdf_wren     = 1'b0;
        DDR2cache_rd_fin = 1'b0;
        DDR2cache_wr_fin = 1'b0;

        case (state_q)
            IDLE: begin
                if (init_calib_complete) begin
                    // A read deferred behind a simultaneous write goes first.
                    if (rd_pend_q) begin
                        rd_pend_d = 1'b0;
                        state_d   = RD_CMD;
                    end else if (wr_req) begin
                        wr_armed_d  = 1'b0;
                        wr_line_d   = cache2DDR_wr_addr[26:4];
                        wr_data_d   = cache2DDR_wr_data;
                        cmd_done_d  = 1'b0;
                        data_done_d = 1'b0;
                        state_d     = WR_XFER;
                        if (rd_req) begin
                            rd_armed_d = 1'b0;
                            rd_pend_d  = 1'b1;
                            rd_line_d  = cache2DDR_rd_addr[26:4];
                        end
                    end else if (rd_req) begin
                        rd_armed_d = 1'b0;
                        rd_line_d  = cache2DDR_rd_addr[26:4];
                        state_d    = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                app_en   = 1'b1;
                app_cmd  = 3'b001;
                app_addr = APP_ADDR_W'({1'b0, rd_line_q, 3'b000});
                if (app_rdy) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rd_data_d = app_rd_data;
                    state_d   = RD_FIN;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = RD_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_FIN: begin
                DDR2cache_rd_fin = 1'b1;
                state_d          = IDLE;
            end
            WR_XFER: begin
                app_en       = !cmd_done_q;
                app_addr     = APP_ADDR_W'({1'b0, wr_line_q, 3'b000});
                app_wdf_wren = !data_done_q;
                cmd_done_d   = cmd_done_q  || app_rdy;
                data_done_d  = data_done_q || app_wdf_rdy;
                if (cmd_done_d && data_done_d) begin
                    state_d = WR_FIN;
                end
            end
            WR_FIN: begin
                DDR2cache_wr_fin = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign app_wdf_end       = app_wdf_wren;
    assign app_wdf_data      = wr_data_q;
    assign DDR2cache_rd_data = rd_data_q;
    assign err               = err_q;
    assign busy              = (state_q != IDLE);

endmodule
`default_nettype wire
